// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg: shared state encoding and width helpers for the adder self-test engine
package adder_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        DONE
    } bist_state_e;

    function automatic int vec_w(input int numbits);
        return 2 * numbits + 1;
    endfunction

    function automatic int cnt_w(input int numbits);
        return 2 * numbits + 2;
    endfunction

endpackage

// File: rtl/adder_bist_checker.sv
// adder_bist_checker: golden-sum compare with run statistics for the adder self-test
module adder_bist_checker
    import adder_bist_pkg::*;
#(
    parameter int NUMBITS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        check,
    input  logic [vec_w(NUMBITS)-1:0]   vec,
    input  logic [NUMBITS-1:0]          a,
    input  logic [NUMBITS-1:0]          b,
    input  logic                        cin,
    input  logic [NUMBITS-1:0]          s,
    input  logic                        cout,
    output logic                        mismatch,
    output logic [cnt_w(NUMBITS)-1:0]   tests_run,
    output logic [cnt_w(NUMBITS)-1:0]   err_count,
    output logic [vec_w(NUMBITS)-1:0]   first_fail
);
    localparam int CW = cnt_w(NUMBITS);

    logic [NUMBITS:0] golden;

    assign golden   = {1'b0, a} + {1'b0, b} + {{NUMBITS{1'b0}}, cin};
    assign mismatch = golden != {cout, s};

    // Statistics clear on a new run and advance once per checked vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tests_run  <= '0;
            err_count  <= '0;
            first_fail <= '0;
        end else if (clear) begin
            tests_run  <= '0;
            err_count  <= '0;
            first_fail <= '0;
        end else if (check) begin
            tests_run <= tests_run + CW'(1);
            if (mismatch) begin
                err_count <= err_count + CW'(1);
                if (err_count == '0)
                    first_fail <= vec;
            end
        end
    end

endmodule

// File: rtl/adder_bist.sv
// adder_bist: exhaustive clocked self-test engine for an adder instance
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int NUMBITS       = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [NUMBITS-1:0]          dut_a,
    output logic [NUMBITS-1:0]          dut_b,
    output logic                        dut_cin,
    input  logic [NUMBITS-1:0]          dut_s,
    input  logic                        dut_cout,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [cnt_w(NUMBITS)-1:0]   tests_run,
    output logic [cnt_w(NUMBITS)-1:0]   err_count,
    output logic [vec_w(NUMBITS)-1:0]   first_fail
);
    localparam int VW = vec_w(NUMBITS);
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);

    bist_state_e   state;
    logic [VW-1:0] v;
    logic [SW-1:0] cnt;
    logic          mismatch;
    logic          clear;
    logic          check;

    assign clear = (state == IDLE || state == DONE) && start;
    assign check = state == CHECK;

    // Sequencer: vector register, settle down-counter and status flags; operands move only when entering APPLY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            v       <= '0;
            cnt     <= '0;
            dut_a   <= '0;
            dut_b   <= '0;
            dut_cin <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state                   <= APPLY;
                    v                       <= '0;
                    {dut_a, dut_b, dut_cin} <= '0;
                    busy                    <= 1'b1;
                    done                    <= 1'b0;
                    pass                    <= 1'b0;
                end
                APPLY: begin
                    state <= SETTLE_CYCLES > 0 ? SETTLE : CHECK;
                    cnt   <= SETTLE_LOAD;
                end
                SETTLE: if (cnt == '0) state <= CHECK; else cnt <= cnt - SW'(1);
                CHECK: if (&v) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= err_count == '0 && !mismatch;
                end else begin
                    state                   <= APPLY;
                    v                       <= v + VW'(1);
                    {dut_a, dut_b, dut_cin} <= v + VW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    adder_bist_checker #(.NUMBITS(NUMBITS)) u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .check     (check),
        .vec       (v),
        .a         (dut_a),
        .b         (dut_b),
        .cin       (dut_cin),
        .s         (dut_s),
        .cout      (dut_cout),
        .mismatch  (mismatch),
        .tests_run (tests_run),
        .err_count (err_count),
        .first_fail(first_fail)
    );

endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: randomized fault-injection bench for adder_bist against a cycle-count model
module tb_adder_bist;
    localparam int S   = 3;
    localparam int P   = S + 2;
    localparam int NV  = 512;
    localparam int RUN = NV * P;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start_p = 1'b0;

    logic [3:0] ma, mb, ms;
    logic       mcin, mcout, busy, done, pass;
    logic [9:0] tests_run, err_count;
    logic [8:0] first_fail;

    logic [3:0] p0_a, p0_b, p0_s, p1_a, p1_b, p1_s;
    logic       p0_cin, p0_cout, p0_busy, p0_done, p0_pass;
    logic       p1_cin, p1_cout, p1_busy, p1_done, p1_pass;
    logic [9:0] p0_tr, p0_ec, p1_tr, p1_ec;
    logic [8:0] p0_ff, p1_ff;

    int         mode = 0;
    logic [4:0] flip [NV];
    bit         bad [NV];
    int         ecnt_n [NV+1];
    int         ffirst_n [NV+1];
    int         ecnt [NV+1];
    int         ffirst [NV+1];
    int         n_chk = 0;
    int         n_fail = 0;
    bit         running = 1'b0;
    int         k = 0;

    always #5 clk = ~clk;

    // adder under test for the main engine: ideal, bit-0 stuck low, or random flips per vector
    logic [4:0] ideal, res;
    logic [8:0] idx;
    always_comb begin
        idx   = {ma, mb, mcin};
        ideal = 5'(ma) + 5'(mb) + 5'(mcin);
        res   = mode == 1 ? (ideal & 5'b11110) : mode == 2 ? (ideal ^ flip[idx]) : ideal;
    end
    assign {mcout, ms} = res;

    // two-stage registered adders for the settle-latency sweep
    logic [4:0] p0_r1 = '0, p0_r2 = '0, p1_r1 = '0, p1_r2 = '0;
    always @(posedge clk) begin
        p0_r1 <= 5'(p0_a) + 5'(p0_b) + 5'(p0_cin);
        p0_r2 <= p0_r1;
        p1_r1 <= 5'(p1_a) + 5'(p1_b) + 5'(p1_cin);
        p1_r2 <= p1_r1;
    end
    assign {p0_cout, p0_s} = p0_r2;
    assign {p1_cout, p1_s} = p1_r2;

    adder_bist #(.NUMBITS(4), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_a(ma), .dut_b(mb), .dut_cin(mcin), .dut_s(ms), .dut_cout(mcout),
        .busy(busy), .done(done), .pass(pass),
        .tests_run(tests_run), .err_count(err_count), .first_fail(first_fail)
    );

    adder_bist #(.NUMBITS(4), .SETTLE_CYCLES(0)) dut_p0 (
        .clk(clk), .rst_n(rst_n), .start(start_p),
        .dut_a(p0_a), .dut_b(p0_b), .dut_cin(p0_cin), .dut_s(p0_s), .dut_cout(p0_cout),
        .busy(p0_busy), .done(p0_done), .pass(p0_pass),
        .tests_run(p0_tr), .err_count(p0_ec), .first_fail(p0_ff)
    );

    adder_bist #(.NUMBITS(4), .SETTLE_CYCLES(1)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .start(start_p),
        .dut_a(p1_a), .dut_b(p1_b), .dut_cin(p1_cin), .dut_s(p1_s), .dut_cout(p1_cout),
        .busy(p1_busy), .done(p1_done), .pass(p1_pass),
        .tests_run(p1_tr), .err_count(p1_ec), .first_fail(p1_ff)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // fault table for the next run: which vectors the adder gets wrong, and running tallies
    task automatic build();
        ecnt_n[0]   = 0;
        ffirst_n[0] = 0;
        for (int i = 0; i < NV; i++) begin
            bad[i] = mode == 1 ? (((i / 32) + ((i / 2) % 16) + (i % 2)) % 2 == 1)
                   : mode == 2 ? (flip[i] != 5'd0) : 1'b0;
            ecnt_n[i+1]   = ecnt_n[i] + int'(bad[i]);
            ffirst_n[i+1] = (ecnt_n[i] == 0 && bad[i]) ? i : ffirst_n[i];
        end
    endtask

    // model: cycles elapsed since the accepted start edge; a run is idle/done when not counting
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            k       <= 0;
        end else if (start && !(running && k < RUN)) begin
            running <= 1'b1;
            k       <= 0;
            ecnt    <= ecnt_n;
            ffirst  <= ffirst_n;
        end else if (running && k < RUN) begin
            k <= k + 1;
        end
    end

    function automatic int tr_now();
        return running ? k / P : 0;
    endfunction

    function automatic int vec_now();
        return !running ? 0 : tr_now() < NV ? tr_now() : NV - 1;
    endfunction

    // every-cycle comparison of the main engine against the model
    always @(negedge clk) begin
        chk("busy", int'(busy), int'(running && k < RUN));
        chk("done", int'(done), int'(running && k >= RUN));
        chk("pass", int'(pass), int'(running && k >= RUN && ecnt[NV] == 0));
        chk("vector", int'({ma, mb, mcin}), vec_now());
        chk("tests_run", int'(tests_run), tr_now());
        chk("err_count", int'(err_count), ecnt[tr_now()]);
        chk("first_fail", int'(first_fail), ffirst[tr_now()]);
    end

    task automatic pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_main(input int limit, output int n);
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic zeros(input string nm);
        chk({nm, "_a"}, int'(ma), 0);
        chk({nm, "_b"}, int'(mb), 0);
        chk({nm, "_cin"}, int'(mcin), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_pass"}, int'(pass), 0);
        chk({nm, "_tests_run"}, int'(tests_run), 0);
        chk({nm, "_err_count"}, int'(err_count), 0);
        chk({nm, "_first_fail"}, int'(first_fail), 0);
    endtask

    int n, p0n, p1n;

    initial begin
        build();
        #12;
        zeros("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ideal adder, start repeated mid-run, latency sweep in parallel
        mode = 0;
        build();
        @(negedge clk);
        start   = 1'b1;
        start_p = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        start_p = 1'b0;
        fork
            begin
                n = 0;
                while (!done && n < RUN + 100) begin
                    @(negedge clk);
                    n++;
                    start = (n == 1000);
                end
                start = 1'b0;
            end
            begin
                p0n = 0;
                while (!p0_done && p0n < 3000) begin
                    @(negedge clk);
                    p0n++;
                end
            end
            begin
                p1n = 0;
                while (!p1_done && p1n < 3000) begin
                    @(negedge clk);
                    p1n++;
                end
            end
        join
        chk("ideal_done_cycle", n, 2560);
        chk("ideal_tests_run", int'(tests_run), 512);
        chk("ideal_err_count", int'(err_count), 0);
        chk("ideal_pass", int'(pass), 1);
        chk("ideal_first_fail", int'(first_fail), 0);
        chk("settle0_done_cycle", p0n, 1024);
        chk("settle0_has_errors", int'(p0_ec > 0), 1);
        chk("settle0_pass", int'(p0_pass), 0);
        chk("settle1_done_cycle", p1n, 1536);
        chk("settle1_pass", int'(p1_pass), 1);
        chk("settle1_err_count", int'(p1_ec), 0);
        chk("settle1_tests_run", int'(p1_tr), 512);

        // sum bit 0 stuck low
        mode = 1;
        build();
        chk("model_stuck_errors", ecnt_n[NV], 256);
        pulse();
        wait_main(RUN + 100, n);
        chk("stuck_done_cycle", n, 2560);
        chk("stuck_err_count", int'(err_count), 256);
        chk("stuck_first_fail", int'(first_fail), 1);
        chk("stuck_pass", int'(pass), 0);
        chk("stuck_tests_run", int'(tests_run), 512);

        // random fault tables; the first run is aborted by reset around vector 100
        for (int it = 0; it < 3; it++) begin
            mode = 2;
            for (int i = 0; i < NV; i++)
                flip[i] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            build();
            if (it == 0) begin
                pulse();
                wait_main(100 * P + int'($urandom_range(0, P - 1)), n);
                @(posedge clk);
                #3 rst_n = 1'b0;
                #1 zeros("abort");
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
            end
            pulse();
            wait_main(RUN + 100, n);
            chk("rand_done_cycle", n, 2560);
            chk("rand_tests_run", int'(tests_run), 512);
            chk("rand_err_count", int'(err_count), ecnt_n[NV]);
            chk("rand_first_fail", int'(first_fail), ffirst_n[NV]);
            chk("rand_pass", int'(pass), int'(ecnt_n[NV] == 0));
            repeat (3) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_bist.md
# adder_bist

Synthesizable built-in self-test engine for the carry-lookahead adder family (4-bit and n-bit variants). It drives the adder's operand and carry-in inputs exhaustively, waits a programmable settle time, and checks the adder's sum and carry-out against an internal golden sum. It counts vectors and mismatches and reports pass/fail. It sits beside any adder instance and gives on-chip, clocked self-test of the adder datapath.

## Interface
Parameters:
- NUMBITS, 4, operand width of the adder under test
- SETTLE_CYCLES, 3, idle cycles between applying a vector and sampling the result; 0 is legal

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous and active-low; all state clears immediately on assertion
- start  in  1  one-cycle pulse that begins a run; sampled only in IDLE or DONE
- dut_a  out  NUMBITS  operand A to the adder; registered
- dut_b  out  NUMBITS  operand B to the adder; registered
- dut_cin  out  1  carry-in to the adder; registered
- dut_s  in  NUMBITS  sum returned by the adder
- dut_cout  in  1  carry-out returned by the adder
- busy  out  1  high from the cycle after start until DONE is entered
- done  out  1  high while in DONE
- pass  out  1  valid while done is high; 1 when err_count is 0
- tests_run  out  2*NUMBITS+2  number of vectors checked in the current or last run
- err_count  out  2*NUMBITS+2  number of mismatches in the current or last run
- first_fail  out  2*NUMBITS+1  vector index of the first mismatch; 0 if there was none

## Operation
- **Vector index v:** width 2*NUMBITS+1.
  - dut_a = v[2N:N+1], dut_b = v[N:1], dut_cin = v[0].
  - cin changes fastest, then b, then a.
- **FSM states:** IDLE, APPLY, SETTLE, CHECK, DONE.
  - IDLE or DONE with start=1 goes to APPLY. On this transition: v=0, operands are loaded from v=0, and tests_run, err_count and first_fail clear.
  - APPLY goes to SETTLE if SETTLE_CYCLES>0, otherwise to CHECK.
  - SETTLE stays for exactly SETTLE_CYCLES cycles, using a down-counter, then goes to CHECK.
  - In CHECK:
    - Golden sum = dut_a + dut_b + dut_cin, computed at NUMBITS+1 bits with no truncation.
    - It is compared with {dut_cout, dut_s}. A mismatch increments err_count.
    - On the first mismatch of the run, first_fail captures v.
    - tests_run increments on every CHECK.
    - If v is all-ones, go to DONE. Otherwise v increments, the operands load from the new v, and the FSM goes to APPLY.
  - DONE holds until start.
- **start handling:** start in APPLY, SETTLE or CHECK is ignored.
- **Counter width:** counters cannot overflow. The maximum count is 2^(2N+1), which is below 2^(2N+2).
- **Reset values:** dut_a=0, dut_b=0, dut_cin=0, busy=0, done=0, pass=0, tests_run=0, err_count=0, first_fail=0, state=IDLE.
- **Reset mid-run:** aborts immediately with no partial result retained. The next start runs a full sweep.

## Timing
- Operands change only on the clock edge that enters APPLY.
- The result is sampled on the edge that leaves CHECK. The adder therefore gets SETTLE_CYCLES+2 cycles of stable inputs.
- Cycles per vector = SETTLE_CYCLES+2.
- A run lasts 2^(2N+1)*(SETTLE_CYCLES+2) cycles from the start edge to done rising. With the defaults this is 512*5 = 2560 cycles.
- busy and done are registered, and are never high together.
- pass, tests_run and err_count are stable from the cycle done rises until the next start.
- A pipelined adder with L registered stages needs SETTLE_CYCLES ≥ L−1.

## Structure
- Package adder_bist_pkg holds:
  - the state enum (bist_state_e)
  - the localparam helpers VEC_W = 2*NUMBITS+1 and CNT_W = 2*NUMBITS+2, supplied as functions of NUMBITS
- One sub-module is natural: adder_bist_checker.
  - It contains the golden-sum compare, err_count, first_fail capture and tests_run.
  - It is enabled by a check strobe from the FSM.
- The FSM, settle counter and vector register stay in the top module.

## Test plan
- **Reset:** assert rst_n=0 mid-clock → every output reads 0 with no clock edge, and state is IDLE.
- **Ideal adder:** combinational ideal adder, NUMBITS=4, SETTLE_CYCLES=3, one start pulse → done rises 2560 cycles later; tests_run=512, err_count=0, pass=1, first_fail=0.
- **Stuck-at fault:** dut_s[0] stuck at 0 → err_count=256, pass=0, first_fail=1 (a=0, b=0, cin=1).
- **Start while busy:** pulse start again at cycle 1000 of a run → no restart; done still at cycle 2560 with tests_run=512.
- **Reset mid-run:** drop rst_n at vector 100, release it, pulse start → a full 512-vector run completes with fresh counts; err_count does not include any prior errors.
- **Latency sweep:** adder with 2 output register stages:
  - SETTLE_CYCLES=0 → err_count>0 and pass=0.
  - SETTLE_CYCLES=1 → pass=1, done after 512*3 = 1536 cycles.
